// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: releases peripheral then core reset domains with programmable
// delays, handles sw/watchdog warm resets and records the last reset cause.
module reset_seq_ctrl #(
  parameter int PERIP_DLY = 16,
  parameter int CORE_DLY  = 32,
  parameter int CNT_W     = 8
) (
  input  logic       dclk,
  input  logic       arst_n,
  input  logic       scan_mode,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  output logic       perip_rst_n,
  output logic       core_rst_n,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  generate
    if (PERIP_DLY < 1 || PERIP_DLY >= (1 << CNT_W)) begin : g_bad_perip
      $error("reset_seq_ctrl: PERIP_DLY out of range 1..2^CNT_W-1");
    end
    if (CORE_DLY < 1 || CORE_DLY >= (1 << CNT_W)) begin : g_bad_core
      $error("reset_seq_ctrl: CORE_DLY out of range 1..2^CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] PERIP_LAST = CNT_W'(PERIP_DLY - 1);
  localparam logic [CNT_W-1:0] CORE_LAST  = CNT_W'(CORE_DLY - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    PERIP = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             perip_q, perip_d;
  logic             core_q, core_d;
  logic             done_q, done_d;
  logic [1:0]       cause_q, cause_d;

  always_ff @(posedge dclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      perip_q <= 1'b0;
      core_q  <= 1'b0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perip_q <= perip_d;
      core_q  <= core_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perip_d = perip_q;
    core_d  = core_q;
    done_d  = done_q;
    cause_d = cause_q;
    unique case (state_q)
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PERIP_LAST) begin
          perip_d = 1'b1;
          cnt_d   = '0;
          state_d = PERIP;
        end
      end
      PERIP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CORE_LAST) begin
          core_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // requests are only honoured here; earlier ones are dropped, not queued
        if (wdt_rst_req || sw_rst_req) begin
          perip_d = 1'b0;
          core_d  = 1'b0;
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = HOLD;
          cause_d = wdt_rst_req ? CAUSE_WDT : CAUSE_SW;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // DFT bypass: reset outputs follow the raw reset, FSM state is untouched
  assign perip_rst_n = scan_mode ? arst_n : perip_q;
  assign core_rst_n  = scan_mode ? arst_n : core_q;
  assign rst_done    = done_q;
  assign rst_cause   = cause_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: default timing instance plus a 1/1 corner instance.
module tb_reset_seq_ctrl;

  logic       dclk = 1'b0;
  logic       arst_n, scan_mode, sw_rst_req, wdt_rst_req;
  logic       perip_rst_n, core_rst_n, rst_done;
  logic [1:0] rst_cause;

  logic       arst1_n, sw1;
  logic       perip1, core1, done1;
  logic [1:0] cause1;

  int total = 0;
  int bad   = 0;

  always #5 dclk = ~dclk;

  reset_seq_ctrl u_dut (
    .dclk        (dclk),
    .arst_n      (arst_n),
    .scan_mode   (scan_mode),
    .sw_rst_req  (sw_rst_req),
    .wdt_rst_req (wdt_rst_req),
    .perip_rst_n (perip_rst_n),
    .core_rst_n  (core_rst_n),
    .rst_done    (rst_done),
    .rst_cause   (rst_cause)
  );

  reset_seq_ctrl #(.PERIP_DLY(1), .CORE_DLY(1)) u_dut1 (
    .dclk        (dclk),
    .arst_n      (arst1_n),
    .scan_mode   (1'b0),
    .sw_rst_req  (sw1),
    .wdt_rst_req (1'b0),
    .perip_rst_n (perip1),
    .core_rst_n  (core1),
    .rst_done    (done1),
    .rst_cause   (cause1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge dclk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic p, input logic c,
                         input logic d, input logic [1:0] ca);
    chk({tag, ".perip"}, 32'(perip_rst_n), 32'(p));
    chk({tag, ".core"},  32'(core_rst_n),  32'(c));
    chk({tag, ".done"},  32'(rst_done),    32'(d));
    chk({tag, ".cause"}, 32'(rst_cause),   32'(ca));
  endtask

  initial begin
    arst_n = 1'b0; scan_mode = 1'b0; sw_rst_req = 1'b0; wdt_rst_req = 1'b0;
    arst1_n = 1'b0; sw1 = 1'b0;

    // power-on
    tick(5);
    chk_all("por_hold", 0, 0, 0, 2'b00);
    arst_n = 1'b1;
    tick(15);
    chk_all("por_e15", 0, 0, 0, 2'b00);
    tick(1);
    chk_all("por_e16", 1, 0, 0, 2'b00);
    tick(31);
    chk_all("por_e47", 1, 0, 0, 2'b00);
    tick(1);
    chk_all("por_e48", 1, 1, 1, 2'b00);

    // software warm reset
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    chk_all("sw_req", 0, 0, 0, 2'b01);
    tick(15);
    chk_all("sw_e15", 0, 0, 0, 2'b01);
    tick(1);
    chk_all("sw_e16", 1, 0, 0, 2'b01);
    tick(31);
    chk_all("sw_e47", 1, 0, 0, 2'b01);
    tick(1);
    chk_all("sw_e48", 1, 1, 1, 2'b01);

    // simultaneous requests: watchdog wins; wdt pulse in PERIP is dropped
    sw_rst_req = 1'b1; wdt_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0; wdt_rst_req = 1'b0;
    chk_all("both_req", 0, 0, 0, 2'b10);
    tick(16);
    chk_all("both_e16", 1, 0, 0, 2'b10);
    wdt_rst_req = 1'b1;
    tick(1);
    wdt_rst_req = 1'b0;
    chk_all("wdt_ign", 1, 0, 0, 2'b10);
    tick(30);
    chk_all("both_e47", 1, 0, 0, 2'b10);
    tick(1);
    chk_all("both_e48", 1, 1, 1, 2'b10);

    // async reset in the middle of a replay
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(19);
    chk_all("mid_e19", 1, 0, 0, 2'b01);
    tick(1);
    arst_n = 1'b0;
    #1;
    chk_all("mid_arst", 0, 0, 0, 2'b00);
    tick(3);
    arst_n = 1'b1;
    tick(15);
    chk_all("mid_e15", 0, 0, 0, 2'b00);
    tick(1);
    chk_all("mid_e16", 1, 0, 0, 2'b00);
    tick(32);
    chk_all("mid_e48", 1, 1, 1, 2'b00);

    // scan bypass within one half period, no clock edge in between
    scan_mode = 1'b1;
    arst_n = 1'b0;
    #1;
    chk_all("scan_lo", 0, 0, 0, 2'b00);
    arst_n = 1'b1;
    #1;
    chk_all("scan_hi", 1, 1, 0, 2'b00);
    arst_n = 1'b0;
    #1;
    chk("scan_lo2.perip", 32'(perip_rst_n), 32'd0);
    chk("scan_lo2.core",  32'(core_rst_n),  32'd0);
    scan_mode = 1'b0;
    tick(1);
    arst_n = 1'b1;

    // 1/1 corner with a held software request
    arst1_n = 1'b1;
    tick(1);
    chk("c_e1.perip", 32'(perip1), 32'd1);
    chk("c_e1.core",  32'(core1),  32'd0);
    tick(1);
    chk("c_e2.core",  32'(core1),  32'd1);
    chk("c_e2.done",  32'(done1),  32'd1);
    chk("c_e2.cause", 32'(cause1), 32'd0);
    sw1 = 1'b1;
    tick(1);
    chk("c_r1.perip", 32'(perip1), 32'd0);
    chk("c_r1.done",  32'(done1),  32'd0);
    chk("c_r1.cause", 32'(cause1), 32'd1);
    tick(1);
    chk("c_r1p.perip", 32'(perip1), 32'd1);
    chk("c_r1p.core",  32'(core1),  32'd0);
    tick(1);
    chk("c_r1c.done", 32'(done1), 32'd1);
    tick(1);
    chk("c_r2.done",  32'(done1),  32'd0);
    chk("c_r2.perip", 32'(perip1), 32'd0);
    sw1 = 1'b0;
    tick(2);
    chk("c_end.done", 32'(done1), 32'd1);
    tick(2);
    chk("c_hold.done", 32'(done1), 32'd1);
    chk("c_hold.core", 32'(core1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
